// File: rtl/gpio_sw_shifter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sw_shifter
// Description : Samples the 10 board switches through a two-flop
//               synchronizer. When the synchronized value differs from the
//               last value sent, it shifts that value out MSB-first on a
//               three-wire SCLK/SDATA/LATCH serial link. It also drives
//               status and debug fields onto the GPIO header.
//
// Ports       : CLOCK_50  in   1  board clock, rising-edge active
//               RESET     in   1  asynchronous, active-high reset
//               SW        in  10  switch inputs (asynchronous to CLOCK_50)
//               GPIO      out 32  [0] SCLK  [1] SDATA  [2] LATCH  [3] BUSY
//                                 [7:4] bit index  [15:8] frame counter
//                                 [21:16] zero  [31:22] last value sent
// Parameters  : DIV       serial clock half-period in CLOCK_50 cycles (1..255)
// Revision    : 1.0  initial release
// ============================================================================
module gpio_sw_shifter #(
    parameter int DIV = 25
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [9:0]  SW,
    output logic [31:0] GPIO
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LO    = 2'd1,
        S_HI    = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    // Terminal count of the half-period divider.
    localparam logic [7:0] c_div_last = 8'(DIV - 1);

    logic [9:0] r_sw_meta;
    logic [9:0] r_sw_s;
    logic [9:0] r_last_sent;
    logic [9:0] r_shreg;
    logic [3:0] r_bitcnt;
    logic [7:0] r_divcnt;
    logic [7:0] r_frames;
    state_t     r_state;

    state_t     w_state_nxt;
    logic [9:0] w_last_nxt;
    logic [9:0] w_shreg_nxt;
    logic [3:0] w_bitcnt_nxt;
    logic [7:0] w_divcnt_nxt;
    logic [7:0] w_frames_nxt;
    logic       w_div_done;

    logic       w_sclk;
    logic       w_sdata;
    logic       w_latch;
    logic       w_busy;
    logic [3:0] w_bit_idx;

    // ------------------------------------------------------------------
    // State register (also holds the switch synchronizer)
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_sw_meta   <= '0;
            r_sw_s      <= '0;
            r_last_sent <= '0;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_divcnt    <= '0;
            r_frames    <= '0;
            r_state     <= S_IDLE;
        end else begin
            r_sw_meta   <= SW;
            r_sw_s      <= r_sw_meta;
            r_last_sent <= w_last_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_divcnt    <= w_divcnt_nxt;
            r_frames    <= w_frames_nxt;
            r_state     <= w_state_nxt;
        end
    end

    assign w_div_done = (r_divcnt == c_div_last);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last_sent;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_divcnt_nxt = r_divcnt;
        w_frames_nxt = r_frames;
        w_sclk       = 1'b0;
        w_sdata      = 1'b0;
        w_latch      = 1'b0;
        w_busy       = 1'b0;
        w_bit_idx    = 4'd0;

        case (r_state)
            S_IDLE: begin
                // A frame starts only here. Changes seen while a frame is
                // in flight are picked up by this compare once it ends.
                if (r_sw_s != r_last_sent) begin
                    w_shreg_nxt  = r_sw_s;
                    w_last_nxt   = r_sw_s;
                    w_bitcnt_nxt = 4'd0;
                    w_divcnt_nxt = 8'd0;
                    w_state_nxt  = S_LO;
                end
            end

            S_LO: begin
                w_sdata   = r_shreg[9];
                w_busy    = 1'b1;
                w_bit_idx = r_bitcnt;
                if (w_div_done) begin
                    w_divcnt_nxt = 8'd0;
                    w_state_nxt  = S_HI;
                end else begin
                    w_divcnt_nxt = r_divcnt + 8'd1;
                end
            end

            S_HI: begin
                // Data is shifted only when SCLK falls. SDATA therefore
                // stays put for the whole high phase.
                w_sclk    = 1'b1;
                w_sdata   = r_shreg[9];
                w_busy    = 1'b1;
                w_bit_idx = r_bitcnt;
                if (w_div_done) begin
                    w_divcnt_nxt = 8'd0;
                    if (r_bitcnt == 4'd9) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_shreg_nxt  = {r_shreg[8:0], 1'b0};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        w_state_nxt  = S_LO;
                    end
                end else begin
                    w_divcnt_nxt = r_divcnt + 8'd1;
                end
            end

            S_LATCH: begin
                w_latch = 1'b1;
                w_busy  = 1'b1;
                if (w_div_done) begin
                    w_divcnt_nxt = 8'd0;
                    w_frames_nxt = r_frames + 8'd1;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_divcnt_nxt = r_divcnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Every field comes from flops only, so reset clears the header at once.
    assign GPIO = {r_last_sent, 6'd0, r_frames, w_bit_idx,
                   w_busy, w_latch, w_sdata, w_sclk};

endmodule
`default_nettype wire

// File: tb/tb_gpio_sw_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_sw_shifter
// Description : Self-checking bench for gpio_sw_shifter. Two instances run
//               side by side, one with DIV=25 and one with DIV=1. Every cycle
//               both headers are compared against a frame-offset reference
//               model. Table vectors and hand-written sequences cover
//               latency, bit order, framing, resets and counter wrap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_sw_shifter;

    localparam int DIV_A = 25;
    localparam int DIV_B = 1;

    logic        clk   = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic [9:0]  sw_a  = '0;
    logic [9:0]  sw_b  = '0;
    logic [31:0] gpio_a;
    logic [31:0] gpio_b;

    always #10 clk = ~clk;

    gpio_sw_shifter #(.DIV(DIV_A)) u_dut_a (
        .CLOCK_50 (clk),
        .RESET    (rst_a),
        .SW       (sw_a),
        .GPIO     (gpio_a)
    );

    gpio_sw_shifter #(.DIV(DIV_B)) u_dut_b (
        .CLOCK_50 (clk),
        .RESET    (rst_b),
        .SW       (sw_b),
        .GPIO     (gpio_b)
    );

    // ------------------------------------------------------------------
    // Reference model: a frame is just an offset counter from its start.
    // All outputs are computed arithmetically from that offset.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic [9:0]  last;
        logic [9:0]  val;
        logic        busy;
        logic [15:0] off;
        logic [7:0]  frames;
    } model_t;

    model_t m_a = '0;
    model_t m_b = '0;

    function automatic model_t model_step(model_t m, logic [9:0] sw, int d);
        model_t n;
        n    = m;
        n.s1 = sw;
        n.s2 = m.s1;
        if (!m.busy) begin
            if (m.s2 != m.last) begin
                n.busy = 1'b1;
                n.off  = 16'd0;
                n.val  = m.s2;
                n.last = m.s2;
            end
        end else begin
            n.off = m.off + 16'd1;
            if (int'(n.off) == 21 * d) begin
                n.busy   = 1'b0;
                n.frames = m.frames + 8'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] model_gpio(model_t m, int d);
        logic [31:0] g;
        int          o;
        int          k;
        g        = '0;
        g[15:8]  = m.frames;
        g[31:22] = m.last;
        if (m.busy) begin
            g[3] = 1'b1;
            o    = int'(m.off);
            if (o < 20 * d) begin
                k       = o / (2 * d);
                g[0]    = ((o % (2 * d)) >= d);
                g[1]    = m.val[9 - k];
                g[7:4]  = 4'(k);
            end else begin
                g[2] = 1'b1;
            end
        end
        return g;
    endfunction

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) m_a <= '0;
        else       m_a <= model_step(m_a, sw_a, DIV_A);
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) m_b <= '0;
        else       m_b <= model_step(m_b, sw_b, DIV_B);
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int act_a    = 0;
    int act_b    = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        check32("model_a", gpio_a, model_gpio(m_a, DIV_A));
        check32("model_b", gpio_b, model_gpio(m_b, DIV_B));
        if (gpio_a[0] | gpio_a[2] | gpio_a[3]) act_a++;
        if (gpio_b[0] | gpio_b[2] | gpio_b[3]) act_b++;
    end

    function automatic logic [31:0] sel(int inst);
        return (inst != 0) ? gpio_b : gpio_a;
    endfunction

    // Waits for BUSY, then records one frame: latency, length, bits sampled
    // on SCLK rises, and LATCH cycles. Returns at the first idle negedge.
    task automatic run_frame(input int inst, output int lat, output int len,
                             output logic [9:0] bits, output int nbits,
                             output int latch_n);
        logic [31:0] g;
        logic        prev_sclk;
        lat = 0; len = 0; bits = '0; nbits = 0; latch_n = 0;
        g = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            g = sel(inst);
            if (g[3]) break;
        end
        if (!g[3]) begin
            n_checks++; n_fail++;
            $display("FAIL frame_start: BUSY not seen within 200 cycles, got 0 required 1 (inst %0d)", inst);
            return;
        end
        len       = 1;
        prev_sclk = g[0];
        if (g[2]) latch_n++;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            g = sel(inst);
            if (!g[3]) break;
            len++;
            if (g[0] && !prev_sclk) begin
                bits = {bits[8:0], g[1]};
                nbits++;
            end
            if (g[2]) latch_n++;
            prev_sclk = g[0];
        end
        if (g[3]) begin
            n_checks++; n_fail++;
            $display("FAIL frame_end: BUSY still high after 10000 cycles, got 1 required 0 (inst %0d)", inst);
        end
    endtask

    typedef struct {
        int         inst;
        logic [9:0] sw;
        int         exp_lat;
        int         exp_len;
        logic [9:0] exp_bits;
        int         exp_latch;
        logic [7:0] exp_frames;
    } vec_t;

    vec_t        tbl[6];
    int          lat, len, nbits, latch_n;
    logic [9:0]  bits;
    logic [7:0]  e_frames;
    logic [31:0] g;

    initial begin
        #(4_000_000);
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 10'h2A5, 3, 525, 10'b1010100101, 25, 8'd1};
        tbl[1] = '{1, 10'h3FF, 3, 21,  10'b1111111111, 1,  8'd1};
        tbl[2] = '{1, 10'h000, 3, 21,  10'b0000000000, 1,  8'd2};
        tbl[3] = '{1, 10'h155, 3, 21,  10'b0101010101, 1,  8'd3};
        tbl[4] = '{1, 10'h001, 3, 21,  10'b0000000001, 1,  8'd4};
        tbl[5] = '{1, 10'h200, 3, 21,  10'b1000000000, 1,  8'd5};

        // ---- reset with SW = 0: header clear, no traffic ----
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check32("reset_gpio_a", gpio_a, 32'h0);
        check32("reset_gpio_b", gpio_b, 32'h0);
        act_a = 0;
        act_b = 0;
        repeat (1000) @(negedge clk);
        check32("idle_busy_a", 32'(act_a), 32'd0);
        check32("idle_busy_b", 32'(act_b), 32'd0);

        // ---- table vectors: single frames on both instances ----
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].inst == 0) sw_a = tbl[i].sw;
            else                  sw_b = tbl[i].sw;
            run_frame(tbl[i].inst, lat, len, bits, nbits, latch_n);
            g = sel(tbl[i].inst);
            check32("tbl_latency",  32'(lat),     32'(tbl[i].exp_lat));
            check32("tbl_busy_len", 32'(len),     32'(tbl[i].exp_len));
            check32("tbl_nbits",    32'(nbits),   32'd10);
            check32("tbl_bits",     32'(bits),    32'(tbl[i].exp_bits));
            check32("tbl_latch",    32'(latch_n), 32'(tbl[i].exp_latch));
            check32("tbl_frames",   32'(g[15:8]), 32'(tbl[i].exp_frames));
            check32("tbl_last",     32'(g[31:22]), 32'(tbl[i].sw));
            check32("tbl_idle_low", 32'(g[7:0]),  32'h0);
        end

        // ---- SW change mid-frame: both values go out, 1-cycle gap ----
        rst_a = 1'b1;
        sw_a  = 10'h000;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        sw_a  = 10'h001;
        fork
            run_frame(0, lat, len, bits, nbits, latch_n);
            begin
                repeat (100) @(negedge clk);
                sw_a = 10'h3FF;
            end
        join
        check32("chg_first_lat",  32'(lat),  32'd3);
        check32("chg_first_len",  32'(len),  32'd525);
        check32("chg_first_bits", 32'(bits), 32'h001);
        run_frame(0, lat, len, bits, nbits, latch_n);
        check32("chg_gap",         32'(lat),  32'd1);
        check32("chg_second_len",  32'(len),  32'd525);
        check32("chg_second_bits", 32'(bits), 32'h3FF);
        check32("chg_frames",      32'(gpio_a[15:8]), 32'd2);

        // ---- reset mid-frame: async clear, then full resend ----
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 10 && !gpio_a[3]; i++) @(negedge clk);
        repeat (200) @(negedge clk);
        check32("midrst_busy_before", 32'(gpio_a[3]), 32'd1);
        #3;
        rst_a = 1'b1;
        #1;
        check32("midrst_async_gpio", gpio_a, 32'h0);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        run_frame(0, lat, len, bits, nbits, latch_n);
        check32("midrst_lat",    32'(lat),  32'd3);
        check32("midrst_len",    32'(len),  32'd525);
        check32("midrst_bits",   32'(bits), 32'h3FF);
        check32("midrst_frames", 32'(gpio_a[15:8]), 32'd1);

        // ---- no change, no traffic ----
        act_a = 0;
        repeat (2000) @(negedge clk);
        check32("quiet_activity", 32'(act_a), 32'd0);

        // ---- frame counter wrap with DIV=1 ----
        e_frames = 8'd5;
        for (int i = 0; i < 256; i++) begin
            sw_b = (i % 2 != 0) ? 10'h0AA : 10'h155;
            run_frame(1, lat, len, bits, nbits, latch_n);
            e_frames = e_frames + 8'd1;
            check32("wrap_len",    32'(len),  32'd21);
            check32("wrap_bits",   32'(bits), 32'(sw_b));
            check32("wrap_frames", 32'(gpio_b[15:8]), 32'(e_frames));
        end
        check32("wrap_final", 32'(gpio_b[15:8]), 32'd5);

        // ---- randomized traffic against the reference model ----
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0)  sw_b = 10'($urandom);
            if ($urandom_range(0, 299) == 0) sw_a = 10'($urandom);
            if (rst_b)                            rst_b = 1'b0;
            else if ($urandom_range(0, 599) == 0) rst_b = 1'b1;
        end
        rst_b = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
